// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry, instruction type encodings and
// the instruction-memory loader state set.
package cpu_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [1:0] TYPE_R   = 2'b00;
  localparam logic [1:0] TYPE_I   = 2'b01;
  localparam logic [1:0] TYPE_LSM = 2'b10;
  localparam logic [1:0] TYPE_BAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  function automatic logic type_legal(input logic [1:0] t);
    case (t)
      TYPE_R, TYPE_I, TYPE_LSM: return 1'b1;
      TYPE_BAD:                 return 1'b0;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/insmem_word_packer.sv
// Assembles little-endian byte stream into instruction words; word_valid
// flags the byte that completes a word, with word_next holding the full word.
module insmem_word_packer #(
  parameter int BYTE_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              take,
  input  logic [BYTE_W-1:0] in_data,
  output logic [DATA_W-1:0] word_next,
  output logic              word_valid
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int IDX_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0]  byte_idx;
  logic [DATA_W-1:0] word_q;

  // word_next includes the byte being accepted this cycle so the FSM can
  // register the complete word on the same edge that takes the last byte.
  always_comb begin
    word_next = word_q;
    word_next[BYTE_W*byte_idx +: BYTE_W] = in_data;
  end

  assign word_valid = take && (byte_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (take) begin
      byte_idx <= byte_idx + 1'b1;
      word_q   <= word_next;
    end
  end

endmodule

// File: rtl/insmem_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them at
// consecutive addresses from 0 and holds the CPU while loading.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, CPU released
// ST_RECV  | accepting stream bytes for the current word
// ST_WRITE | one cycle: word written (wr_en) or rejected for bad type
// ST_DONE  | all words written, done held until next start
// ST_ERR   | bad type or illegal count, err held, CPU kept in hold
module insmem_loader #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int BYTE_W = cpu_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  cpu_pkg::loader_state_e state;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   num_q;
  logic              idle_like;
  logic              count_ok;
  logic              last_word;
  logic              take;
  logic              pk_clear;
  logic [DATA_W-1:0] word_next;
  logic              word_valid;

  assign idle_like = (state == cpu_pkg::ST_IDLE) || (state == cpu_pkg::ST_DONE) ||
                     (state == cpu_pkg::ST_ERR);
  assign count_ok  = (num_words != '0) && (num_words <= MAX_WORDS);
  assign last_word = ({1'b0, addr} == (num_q - 1'b1));
  assign take      = in_valid && in_ready && (state == cpu_pkg::ST_RECV) && !abort;
  assign pk_clear  = abort || (start && idle_like);

  insmem_word_packer #(
    .BYTE_W (BYTE_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .take       (take),
    .in_data    (in_data),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= cpu_pkg::ST_IDLE;
      addr     <= '0;
      num_q    <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      wr_en <= 1'b0;
      if (abort) begin
        state    <= cpu_pkg::ST_IDLE;
        addr     <= '0;
        in_ready <= 1'b0;
        cpu_hold <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b0;
        err      <= 1'b0;
        err_addr <= '0;
      end else begin
        case (state)
          cpu_pkg::ST_IDLE, cpu_pkg::ST_DONE, cpu_pkg::ST_ERR: begin
            if (start) begin
              done     <= 1'b0;
              cpu_hold <= 1'b1;
              addr     <= '0;
              if (count_ok) begin
                state    <= cpu_pkg::ST_RECV;
                num_q    <= num_words;
                in_ready <= 1'b1;
                busy     <= 1'b1;
                err      <= 1'b0;
              end else begin
                state    <= cpu_pkg::ST_ERR;
                err      <= 1'b1;
                err_addr <= '0;
              end
            end
          end
          cpu_pkg::ST_RECV: begin
            if (word_valid) begin
              state    <= cpu_pkg::ST_WRITE;
              in_ready <= 1'b0;
              if (cpu_pkg::type_legal(word_next[1:0])) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= word_next;
              end
            end
          end
          cpu_pkg::ST_WRITE: begin
            // wr_en is high in this cycle exactly when the word was legal
            if (!wr_en) begin
              state    <= cpu_pkg::ST_ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_addr <= addr;
            end else if (last_word) begin
              state    <= cpu_pkg::ST_DONE;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= cpu_pkg::ST_RECV;
              addr     <= addr + 1'b1;
              in_ready <= 1'b1;
            end
          end
          default: state <= cpu_pkg::ST_IDLE;
        endcase
      end
    end
  end

endmodule
